// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I multicycle control FSM sequencing fetch/decode/execute/memory/writeback.
// Optional jalr support is enabled by defining MULTICYCLE_JALR_EN.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] imm_src,
  output logic [3:0] state,
  output logic       illegal
);
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALRADR  = 4'd11,
    S_JALR     = 4'd12,
    S_ILLEGAL  = 4'd15
  } state_t;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  state_t     state_q, state_d, dec_next;
  logic       illegal_q;
  logic       alu_ok, br_ok, jalr_ok;
  logic [2:0] alu_dec;
  logic       mem_req_c, mem_write_c, adr_src_c, ir_write_c, pc_write_c, reg_write_c;
  logic [1:0] result_src_c, alu_src_a_c, alu_src_b_c, imm_src_c;
  logic [2:0] alu_control_c;
  assign alu_ok = (funct3 == 3'b000) || (funct3 == 3'b010) || (funct3 == 3'b110) || (funct3 == 3'b111);
  assign br_ok  = (funct3[2:1] == 2'b00);
`ifdef MULTICYCLE_JALR_EN
  assign jalr_ok = (op == OP_JALR) && (funct3 == 3'b000);
`else
  assign jalr_ok = 1'b0;
`endif
  assign alu_dec = (funct3 == 3'b000) ? ((op == OP_R && funct7b5) ? 3'b001 : 3'b000) :
                   (funct3 == 3'b010) ? 3'b101 :
                   (funct3 == 3'b110) ? 3'b011 :
                   (funct3 == 3'b111) ? 3'b010 : 3'b000;
  assign dec_next = (op == OP_LW || op == OP_SW) ? S_MEMADR :
                    (op == OP_R && alu_ok)       ? S_EXECR :
                    (op == OP_I && alu_ok)       ? S_EXECI :
                    (op == OP_B && br_ok)        ? S_BRANCH :
                    (op == OP_JAL)               ? S_JAL :
                    jalr_ok                      ? S_JALRADR : S_ILLEGAL;
  assign imm_src_c = (op == OP_SW) ? 2'b01 : (op == OP_B) ? 2'b10 : (op == OP_JAL) ? 2'b11 : 2'b00;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:          state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:         state_d = dec_next;
      S_MEMADR:         state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:        state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:          state_d = S_FETCH;
      S_MEMWRITE:       state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR, S_EXECI: state_d = S_ALUWB;
      S_ALUWB:          state_d = S_FETCH;
      S_BRANCH:         state_d = S_FETCH;
      S_JAL, S_JALR:    state_d = S_ALUWB;
      S_JALRADR:        state_d = S_JALR;
      S_ILLEGAL:        state_d = S_ILLEGAL;
      default:          state_d = S_FETCH;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_q | (state_d == S_ILLEGAL);
    end
  end
  always_comb begin
    mem_req_c     = 1'b0;
    mem_write_c   = 1'b0;
    adr_src_c     = 1'b0;
    ir_write_c    = 1'b0;
    pc_write_c    = 1'b0;
    reg_write_c   = 1'b0;
    result_src_c  = 2'b00;
    alu_src_a_c   = 2'b00;
    alu_src_b_c   = 2'b00;
    alu_control_c = 3'b000;
    case (state_q)
      S_FETCH: begin
        mem_req_c    = 1'b1;
        alu_src_b_c  = 2'b10;
        result_src_c = 2'b10;
        ir_write_c   = mem_ready;
        pc_write_c   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a_c = 2'b01;
        alu_src_b_c = 2'b01;
      end
      S_MEMADR, S_JALRADR: begin
        alu_src_a_c = 2'b10;
        alu_src_b_c = 2'b01;
      end
      S_MEMREAD: begin
        mem_req_c = 1'b1;
        adr_src_c = 1'b1;
      end
      S_MEMWB: begin
        result_src_c = 2'b01;
        reg_write_c  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req_c   = 1'b1;
        mem_write_c = 1'b1;
        adr_src_c   = 1'b1;
      end
      S_EXECR: begin
        alu_src_a_c   = 2'b10;
        alu_control_c = alu_dec;
      end
      S_EXECI: begin
        alu_src_a_c   = 2'b10;
        alu_src_b_c   = 2'b01;
        alu_control_c = alu_dec;
      end
      S_ALUWB: reg_write_c = 1'b1;
      S_BRANCH: begin
        alu_src_a_c   = 2'b10;
        alu_control_c = 3'b001;
        pc_write_c    = funct3[0] ? ~zero : zero;
      end
      S_JAL, S_JALR: begin
        alu_src_a_c = 2'b01;
        alu_src_b_c = 2'b10;
        pc_write_c  = 1'b1;
      end
      default: ;
    endcase
  end
  // Reset overrides everything, including the FETCH request the reset state would otherwise raise.
  assign mem_req     = mem_req_c & ~rst;
  assign mem_write   = mem_write_c & ~rst;
  assign adr_src     = adr_src_c & ~rst;
  assign ir_write    = ir_write_c & ~rst;
  assign pc_write    = pc_write_c & ~rst;
  assign reg_write   = reg_write_c & ~rst;
  assign result_src  = rst ? 2'b00 : result_src_c;
  assign alu_src_a   = rst ? 2'b00 : alu_src_a_c;
  assign alu_src_b   = rst ? 2'b00 : alu_src_b_c;
  assign alu_control = rst ? 3'b000 : alu_control_c;
  assign imm_src     = rst ? 2'b00 : imm_src_c;
  assign illegal     = illegal_q & ~rst;
  assign state       = state_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: table-driven check of the multicycle control FSM plus reset and illegal sequences.
module tb_multicycle_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = 7'b0000011;
  logic [2:0] funct3 = 3'b000;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [3:0] state;
  int checks = 0;
  int failures = 0;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .imm_src(imm_src), .state(state), .illegal(illegal)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011;
  localparam logic [6:0] BR = 7'b1100011, JL = 7'b1101111, JR = 7'b1100111;

  // seq holds one state per nibble (cycle 0 in the low nibble); rdy/req are per-cycle bit masks.
  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    int          len;
    logic [31:0] seq;
    logic [7:0]  rdy;
    logic [7:0]  req;
    int          ki;
    logic [4:0]  st;
    logic [5:0]  sel;
    logic [2:0]  alu;
    logic [1:0]  imm;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z,
                              input int len, input logic [31:0] seq, input logic [7:0] rdy,
                              input logic [7:0] req, input int ki, input logic [4:0] st,
                              input logic [5:0] sel, input logic [2:0] alu, input logic [1:0] imm);
    vec_t v;
    v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.len = len; v.seq = seq; v.rdy = rdy; v.req = req;
    v.ki = ki; v.st = st; v.sel = sel; v.alu = alu; v.imm = imm;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [6:0] ill_op[$];
    logic [2:0] ill_f3[$];
    // st = {mem_write, adr_src, ir_write, pc_write, reg_write}; sel = {result_src, alu_src_a, alu_src_b}
    tv.push_back(mk(LW, 3'b010, 1'b0, 1'b0, 6, 32'h00043210, 8'hFF, 8'h29, 4, 5'b00001, 6'b010000, 3'b000, 2'b00));
    tv.push_back(mk(LW, 3'b010, 1'b0, 1'b0, 8, 32'h04333210, 8'hE7, 8'hB9, 4, 5'b01000, 6'b000000, 3'b000, 2'b00));
    tv.push_back(mk(SW, 3'b010, 1'b0, 1'b0, 5, 32'h00005210, 8'hFF, 8'h19, 1, 5'b00000, 6'b000101, 3'b000, 2'b01));
    tv.push_back(mk(SW, 3'b010, 1'b0, 1'b0, 5, 32'h00005210, 8'hFF, 8'h19, 2, 5'b00000, 6'b001001, 3'b000, 2'b01));
    tv.push_back(mk(SW, 3'b010, 1'b0, 1'b0, 7, 32'h00552100, 8'hEE, 8'h73, 4, 5'b11000, 6'b000000, 3'b000, 2'b01));
    tv.push_back(mk(RT, 3'b000, 1'b0, 1'b0, 5, 32'h00008610, 8'hFF, 8'h11, 2, 5'b00000, 6'b001000, 3'b000, 2'b00));
    tv.push_back(mk(RT, 3'b000, 1'b1, 1'b0, 5, 32'h00008610, 8'hFF, 8'h11, 2, 5'b00000, 6'b001000, 3'b001, 2'b00));
    tv.push_back(mk(RT, 3'b111, 1'b0, 1'b0, 5, 32'h00008610, 8'hFF, 8'h11, 2, 5'b00000, 6'b001000, 3'b010, 2'b00));
    tv.push_back(mk(RT, 3'b110, 1'b0, 1'b0, 5, 32'h00008610, 8'hFF, 8'h11, 2, 5'b00000, 6'b001000, 3'b011, 2'b00));
    tv.push_back(mk(RT, 3'b010, 1'b0, 1'b0, 5, 32'h00008610, 8'hFF, 8'h11, 2, 5'b00000, 6'b001000, 3'b101, 2'b00));
    tv.push_back(mk(RT, 3'b000, 1'b0, 1'b0, 5, 32'h00008610, 8'hFF, 8'h11, 3, 5'b00001, 6'b000000, 3'b000, 2'b00));
    tv.push_back(mk(RT, 3'b000, 1'b0, 1'b0, 6, 32'h00086100, 8'hFE, 8'h23, 0, 5'b00000, 6'b100010, 3'b000, 2'b00));
    tv.push_back(mk(IT, 3'b000, 1'b1, 1'b0, 5, 32'h00008710, 8'hFF, 8'h11, 2, 5'b00000, 6'b001001, 3'b000, 2'b00));
    tv.push_back(mk(IT, 3'b110, 1'b0, 1'b0, 5, 32'h00008710, 8'hFF, 8'h11, 2, 5'b00000, 6'b001001, 3'b011, 2'b00));
    tv.push_back(mk(BR, 3'b000, 1'b0, 1'b1, 4, 32'h00000910, 8'hFF, 8'h09, 2, 5'b00010, 6'b001000, 3'b001, 2'b10));
    tv.push_back(mk(BR, 3'b001, 1'b0, 1'b1, 4, 32'h00000910, 8'hFF, 8'h09, 2, 5'b00000, 6'b001000, 3'b001, 2'b10));
    tv.push_back(mk(BR, 3'b001, 1'b0, 1'b0, 4, 32'h00000910, 8'hFF, 8'h09, 2, 5'b00010, 6'b001000, 3'b001, 2'b10));
    tv.push_back(mk(BR, 3'b000, 1'b0, 1'b0, 4, 32'h00000910, 8'hFF, 8'h09, 2, 5'b00000, 6'b001000, 3'b001, 2'b10));
    tv.push_back(mk(JL, 3'b000, 1'b0, 1'b0, 5, 32'h00008A10, 8'hFF, 8'h11, 2, 5'b00010, 6'b000110, 3'b000, 2'b11));
    tv.push_back(mk(JL, 3'b000, 1'b0, 1'b0, 5, 32'h00008A10, 8'hFF, 8'h11, 0, 5'b00110, 6'b100010, 3'b000, 2'b11));
`ifdef MULTICYCLE_JALR_EN
    tv.push_back(mk(JR, 3'b000, 1'b0, 1'b0, 6, 32'h0008CB10, 8'hFF, 8'h21, 2, 5'b00000, 6'b001001, 3'b000, 2'b00));
    tv.push_back(mk(JR, 3'b000, 1'b0, 1'b0, 6, 32'h0008CB10, 8'hFF, 8'h21, 3, 5'b00010, 6'b000110, 3'b000, 2'b00));
`else
    ill_op.push_back(JR); ill_f3.push_back(3'b000);
`endif
    ill_op.push_back(JR);    ill_f3.push_back(3'b001);
    ill_op.push_back(RT);    ill_f3.push_back(3'b001);
    ill_op.push_back(IT);    ill_f3.push_back(3'b101);
    ill_op.push_back(BR);    ill_f3.push_back(3'b010);
    ill_op.push_back(7'h00); ill_f3.push_back(3'b000);

    // Reset behaviour and first fetch, then reset asserted mid-MEMREAD.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", state, 4'd0);
    chk("rst_mem_req", mem_req, 1'b0);
    mem_ready = 1'b1;
    #1;
    chk("rst_ir_pc_write", {ir_write, pc_write, reg_write}, 3'b000);
    chk("rst_selects", {result_src, alu_src_a, alu_src_b, alu_control}, 9'd0);
    rst = 1'b0;
    #1;
    chk("first_fetch_req", {mem_req, ir_write, pc_write}, 3'b111);
    @(posedge clk); #1;
    chk("first_decode", state, 4'd1);
    @(posedge clk); #1;
    chk("lw_memadr", state, 4'd2);
    mem_ready = 1'b0;
    @(posedge clk); #1;
    chk("lw_memread", {state, mem_req, adr_src}, {4'd3, 2'b11});
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("midrst_state", state, 4'd0);
    chk("midrst_strobes", {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write}, 6'd0);
    mem_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("after_rst_req", {state, mem_req, ir_write, pc_write}, {4'd0, 3'b111});

    foreach (tv[v]) begin
      do_reset();
      op = tv[v].op; funct3 = tv[v].f3; funct7b5 = tv[v].f7; zero = tv[v].z;
      for (int i = 0; i < tv[v].len; i++) begin
        mem_ready = tv[v].rdy[i];
        #1;
        chk($sformatf("v%0d_c%0d_state", v, i), state, tv[v].seq[i*4 +: 4]);
        chk($sformatf("v%0d_c%0d_mem_req", v, i), mem_req, tv[v].req[i]);
        if (i == tv[v].ki) begin
          chk($sformatf("v%0d_strobes", v), {mem_write, adr_src, ir_write, pc_write, reg_write}, tv[v].st);
          chk($sformatf("v%0d_selects", v), {result_src, alu_src_a, alu_src_b}, tv[v].sel);
          chk($sformatf("v%0d_alu_control", v), alu_control, tv[v].alu);
          chk($sformatf("v%0d_imm_src", v), imm_src, tv[v].imm);
          chk($sformatf("v%0d_illegal", v), illegal, 1'b0);
        end
        if (i < tv[v].len - 1) begin
          @(posedge clk); #1;
        end
      end
    end

    // Unsupported encodings end in the sticky ILLEGAL state until reset.
    foreach (ill_op[k]) begin
      do_reset();
      op = ill_op[k]; funct3 = ill_f3[k]; funct7b5 = 1'b0; zero = 1'b0;
      #1;
      chk($sformatf("ill%0d_fetch", k), state, 4'd0);
      @(posedge clk); #1;
      chk($sformatf("ill%0d_decode", k), {state, illegal}, {4'd1, 1'b0});
      @(posedge clk); #1;
      chk($sformatf("ill%0d_enter", k), {state, illegal, mem_req}, {4'd15, 2'b10});
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("ill%0d_hold", k), {state, illegal, mem_req, pc_write, reg_write}, {4'd15, 4'b1000});
      rst = 1'b1;
      #1;
      chk($sformatf("ill%0d_clear", k), {state, illegal}, {4'd0, 1'b0});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
